// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a host start pulse with the 40-bit humidity/temperature
// frame on an open-drain single-wire bus, and reports frame completion or abandonment.
module dht11_responder #(
    parameter int CLK_PER_US   = 50,
    parameter int START_MIN_US = 18000,
    parameter int RESP_WAIT_US = 30,
    parameter int RESP_LOW_US  = 80,
    parameter int RESP_HIGH_US = 80,
    parameter int BIT_LOW_US   = 50,
    parameter int BIT0_HIGH_US = 26,
    parameter int BIT1_HIGH_US = 70
) (
    input  logic       clk,
    input  logic       rst_n,
    inout  wire        Data,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] tmp_int,
    input  logic [7:0] tmp_dec,
    input  logic       corrupt_chk,
    output logic       busy,
    output logic       frame_done,
    output logic       abort,
    output logic [7:0] frame_cnt,
    output logic [7:0] checksum
);

    localparam logic [15:0] US_LAST    = 16'(CLK_PER_US - 1);
    localparam logic [15:0] START_MIN  = 16'(START_MIN_US);
    localparam logic [15:0] WAIT_LAST  = 16'(RESP_WAIT_US * CLK_PER_US - 1);
    localparam logic [15:0] RLOW_LAST  = 16'(RESP_LOW_US * CLK_PER_US - 1);
    localparam logic [15:0] RHIGH_LAST = 16'(RESP_HIGH_US * CLK_PER_US - 1);
    localparam logic [15:0] BLOW_LAST  = 16'(BIT_LOW_US * CLK_PER_US - 1);
    localparam logic [15:0] B0_LAST    = 16'(BIT0_HIGH_US * CLK_PER_US - 1);
    localparam logic [15:0] B1_LAST    = 16'(BIT1_HIGH_US * CLK_PER_US - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HOST_LOW, S_WAIT_REL, S_RESP_LOW,
        S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_END_LOW
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] width_q, width_d;
    logic [15:0] low_cnt_q, low_cnt_d;
    logic [5:0]  idx_q, idx_d;
    logic [39:0] frame_q, frame_d;
    logic [7:0]  chk_q, chk_d;
    logic [7:0]  frames_q, frames_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;
    logic        sync1_q, sync2_q, prev_q;
    logic        own1_q, own2_q;

    logic        drive_low;
    logic        monitored;
    logic        sample;
    logic        contention;
    logic [7:0]  sum_w;
    logic [7:0]  chk_w;

    assign drive_low = (state_q == S_RESP_LOW) || (state_q == S_BIT_LOW) || (state_q == S_END_LOW);
    assign monitored = (state_q == S_WAIT_REL) || (state_q == S_RESP_HIGH) || (state_q == S_BIT_HIGH);
    assign Data      = drive_low ? 1'b0 : 1'bz;

    // own1/own2 track our drive through the synchronizer so our own lows read back as high
    assign sample     = sync2_q | own2_q;
    assign contention = monitored && !sample && (low_cnt_q == US_LAST);
    assign low_cnt_d  = (monitored && !sample) ? low_cnt_q + 16'd1 : 16'd0;

    assign sum_w = hum_int + hum_dec + tmp_int + tmp_dec;
    assign chk_w = sum_w ^ {8{corrupt_chk}};

    assign busy       = monitored || drive_low;
    assign frame_done = done_q;
    assign abort      = abort_q;
    assign frame_cnt  = frames_q;
    assign checksum   = chk_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 16'd1;
        width_d  = width_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        chk_d    = chk_q;
        frames_d = frames_q;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                if (prev_q && !sample) begin
                    // the edge cycle itself is the first counted cycle of the host low
                    state_d = S_HOST_LOW;
                    cnt_d   = (US_LAST == 16'd0) ? 16'd0 : 16'd1;
                    width_d = (US_LAST == 16'd0) ? 16'd1 : 16'd0;
                end
            end
            S_HOST_LOW: begin
                if (sample) begin
                    cnt_d = 16'd0;
                    if (width_q >= START_MIN) begin
                        state_d = S_WAIT_REL;
                        frame_d = {hum_int, hum_dec, tmp_int, tmp_dec, chk_w};
                        chk_d   = chk_w;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == US_LAST) begin
                    cnt_d = 16'd0;
                    if (width_q != 16'hFFFF) width_d = width_q + 16'd1;
                end
            end
            S_WAIT_REL: if (cnt_q == WAIT_LAST) begin
                state_d = S_RESP_LOW;
                cnt_d   = 16'd0;
            end
            S_RESP_LOW: if (cnt_q == RLOW_LAST) begin
                state_d = S_RESP_HIGH;
                cnt_d   = 16'd0;
            end
            S_RESP_HIGH: if (cnt_q == RHIGH_LAST) begin
                state_d = S_BIT_LOW;
                cnt_d   = 16'd0;
                idx_d   = 6'd0;
            end
            S_BIT_LOW: if (cnt_q == BLOW_LAST) begin
                state_d = S_BIT_HIGH;
                cnt_d   = 16'd0;
            end
            S_BIT_HIGH: if (cnt_q == (frame_q[39] ? B1_LAST : B0_LAST)) begin
                cnt_d   = 16'd0;
                frame_d = {frame_q[38:0], 1'b0};
                if (idx_q == 6'd39) begin
                    state_d = S_END_LOW;
                end else begin
                    state_d = S_BIT_LOW;
                    idx_d   = idx_q + 6'd1;
                end
            end
            S_END_LOW: if (cnt_q == BLOW_LAST) begin
                state_d  = S_IDLE;
                cnt_d    = 16'd0;
                done_d   = 1'b1;
                frames_d = frames_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
        if (contention) begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
            abort_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            width_q   <= 16'd0;
            low_cnt_q <= 16'd0;
            idx_q     <= 6'd0;
            frame_q   <= 40'd0;
            chk_q     <= 8'd0;
            frames_q  <= 8'd0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            own1_q    <= 1'b0;
            own2_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            width_q   <= width_d;
            low_cnt_q <= low_cnt_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            chk_q     <= chk_d;
            frames_q  <= frames_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            sync1_q   <= Data;
            sync2_q   <= sync1_q;
            prev_q    <= sample;
            own1_q    <= drive_low;
            own2_q    <= own1_q;
        end
    end

endmodule

// File: doc/dht11_responder.md
Name: dht11_responder

Overview:
- Synthesizable DHT11 sensor emulator. It is the responder end of the single-wire humidity/temperature protocol, answering a host that issues a start pulse and reads a 40-bit frame.
- Used on-board for loopback bring-up of the DHT11 reader/LCD path without a physical sensor, and as a bench responder.
- Drives the shared Data line open-drain (low or Z; external pull-up assumed). Reports frame status to local logic.

Parameters:
CLK_PER_US, 50, clk cycles per microsecond (50 MHz)
START_MIN_US, 18000, minimum host low width accepted as a start request
RESP_WAIT_US, 30, delay from host release to response start
RESP_LOW_US, 80, response low phase
RESP_HIGH_US, 80, response high (released) phase
BIT_LOW_US, 50, low lead-in before every bit and end marker
BIT0_HIGH_US, 26, released width encoding 0
BIT1_HIGH_US, 70, released width encoding 1

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  synchronous reset, active-low
Data  inout  1  single-wire bus; driven 0 or Z only, never driven 1
hum_int  input  8  humidity integer byte
hum_dec  input  8  humidity decimal byte
tmp_int  input  8  temperature integer byte
tmp_dec  input  8  temperature decimal byte
corrupt_chk  input  1  fault injection: 1 = transmit inverted checksum
busy  output  1  high from accepted start until frame end/abort
frame_done  output  1  one-cycle pulse after end marker completes
abort  output  1  one-cycle pulse when a frame is abandoned
frame_cnt  output  8  completed-frame counter, wraps 255->0
checksum  output  8  checksum byte of last snapshot, as sent

Behaviour:
- Reset (rst_n=0 at clk edge): Data released (Z), state IDLE, busy=0, frame_done=0, abort=0, frame_cnt=0, checksum=0. Reset mid-frame releases the bus on that same edge.
- Data is sampled through a 2-FF synchronizer (2-cycle latency). The sample is ignored while the block drives low.
- Phase timing uses a cycle counter cleared on state entry. A phase of N us lasts exactly N*CLK_PER_US clocks.
- Host low width is counted in whole us from the synchronized falling edge and saturates at 65535.
- States and transitions:
  - IDLE: synchronized falling edge -> HOST_LOW.
  - HOST_LOW: on synchronized rise, if width >= START_MIN_US -> WAIT_REL, busy=1, snapshot the four bytes and checksum; otherwise -> IDLE silently.
  - WAIT_REL: released for RESP_WAIT_US -> RESP_LOW.
  - RESP_LOW: drive low RESP_LOW_US -> RESP_HIGH.
  - RESP_HIGH: release RESP_HIGH_US -> BIT_LOW, bit index=0.
  - BIT_LOW: drive low BIT_LOW_US -> BIT_HIGH.
  - BIT_HIGH: release BIT0_HIGH_US or BIT1_HIGH_US by current bit; index<39 -> BIT_LOW with index+1, else -> END_LOW.
  - END_LOW: drive low BIT_LOW_US, then release -> IDLE; frame_done=1 for one cycle, frame_cnt+1, busy=0.
- Frame order, MSB first: hum_int, hum_dec, tmp_int, tmp_dec, checksum.
- checksum = (hum_int+hum_dec+tmp_int+tmp_dec) mod 256, XOR 0xFF when corrupt_chk=1. corrupt_chk is sampled at snapshot.
- Input changes after the snapshot do not affect the frame in flight.
- Contention: in WAIT_REL, RESP_HIGH or BIT_HIGH, a synchronized low seen for >= CLK_PER_US consecutive cycles has these effects:
  - state -> IDLE, bus released, abort pulse, busy=0;
  - frame_cnt unchanged;
  - that falling edge is not reused as a new start.
- A new host falling edge while busy and driving is ignored. A new start is recognized only from IDLE.

Test Plan:
- hum_int=0x37, hum_dec=0x00, tmp_int=0x18, tmp_dec=0x03; host low 18 ms then release -> 40 decoded bits 37 00 18 03 52, checksum=0x52; Data first low 30 us after release; total release-to-final-release 3808 us; frame_done once; frame_cnt=1.
- Host low 10 ms then release -> no bus activity, busy stays 0, no frame_done.
- Same bytes with corrupt_chk=1 -> fifth byte 0xAD, checksum output 0xAD; first four bytes unchanged.
- hum_int changed 0x37->0x40 during BIT_LOW of bit 5 -> frame still carries 0x37; next frame carries 0x40 with checksum 0x5B.
- Host holds Data low 5 us during BIT_HIGH of bit 10 -> abort pulse, busy=0, bus released, frame_cnt unchanged; a following valid 18 ms start produces a full frame.
- rst_n low at RESP_LOW midpoint -> Data Z on that edge, all outputs at reset values; 256 complete frames -> frame_cnt wraps to 0.
